// File: rtl/chain_code_pkg.sv
// Shared definitions for the chain-code encoder/decoder pair: image size,
// field widths, state encoding and the Freeman direction offsets.
package chain_code_pkg;

  localparam int DIM    = 64;
  localparam int CoordW = 6;
  localparam int PerimW = 9;
  localparam int AreaW  = 12;

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StSearch,
    StEmit,
    StDone
  } state_e;

  // Row offset for direction d, as a 7-bit two's-complement value.
  function automatic logic [6:0] dir_dr(input logic [2:0] d);
    case (d)
      3'd1, 3'd2, 3'd3: dir_dr = 7'h7f;
      3'd5, 3'd6, 3'd7: dir_dr = 7'h01;
      default:          dir_dr = 7'h00;
    endcase
  endfunction

  // Column offset for direction d, as a 7-bit two's-complement value.
  function automatic logic [6:0] dir_dc(input logic [2:0] d);
    case (d)
      3'd0, 3'd1, 3'd7: dir_dc = 7'h01;
      3'd3, 3'd4, 3'd5: dir_dc = 7'h7f;
      default:          dir_dc = 7'h00;
    endcase
  endfunction

  // First neighbour to probe after arriving along direction d.
  function automatic logic [2:0] first_probe(input logic [2:0] d);
    first_probe = d[0] ? d + 3'd6 : d + 3'd7;
  endfunction

endpackage

// File: rtl/chain_code_row_scan.sv
// Combinational summary of one image row: popcount, any-set flag and the
// leftmost set column (column c lives in bit 63-c).
module chain_code_row_scan
  import chain_code_pkg::*;
(
  input  logic [DIM-1:0]    row,
  output logic [6:0]        popcount,
  output logic              nonzero,
  output logic [CoordW-1:0] lead_col
);

  // Popcount and leftmost column; descending loop lets the smallest column win.
  always_comb begin
    popcount = '0;
    lead_col = '0;
    for (int i = 0; i < DIM; i++) begin
      popcount = popcount + 7'(row[i]);
    end
    for (int c = DIM - 1; c >= 0; c--) begin
      if (row[DIM-1-c]) lead_col = CoordW'(c);
    end
  end

  assign nonzero = |row;

endmodule

// File: rtl/chain_code_encoder.sv
// Traces the outer boundary of one object in a 64x64 binary image and emits
// its Freeman chain code over a valid/ready handshake.
module chain_code_encoder
  import chain_code_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [CoordW-1:0] load_row,
  input  logic [DIM-1:0]    load_data,
  input  logic              start,
  output logic [7:0]        code,
  output logic              code_valid,
  input  logic              code_ready,
  output logic [CoordW-1:0] startX,
  output logic [CoordW-1:0] startY,
  output logic [AreaW-1:0]  area,
  output logic [PerimW-1:0] perimeter,
  output logic              done,
  output logic              error
);

  logic [DIM-1:0] img [DIM];

  state_e            state_q, state_d;
  logic [CoordW-1:0] row_q, row_d;
  logic [AreaW:0]    area_q, area_d;     // one extra bit to spot a full image
  logic              found_q, found_d;
  logic [CoordW-1:0] sx_q, sx_d, sy_q, sy_d;
  logic [CoordW-1:0] cx_q, cx_d, cy_q, cy_d;
  logic [2:0]        d_q, d_d;
  logic [2:0]        probe_q, probe_d;
  logic [PerimW-1:0] perim_q, perim_d;
  logic              fail_q, fail_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [6:0]        pop;
  logic              nz;
  logic [CoordW-1:0] lead;

  logic [2:0]        probe_dir;
  logic [6:0]        nr, nc;
  logic              probe_pix;
  logic [CoordW-1:0] mr, mc;

  // Image store: written only while idle, deliberately not reset.
  always_ff @(posedge clk) begin
    if (load_valid && (state_q == StIdle)) img[load_row] <= load_data;
  end

  chain_code_row_scan u_row_scan (
    .row      (img[row_q]),
    .popcount (pop),
    .nonzero  (nz),
    .lead_col (lead)
  );

  // Neighbour probe; bit 6 of the 7-bit coordinate flags out-of-image.
  always_comb begin
    probe_dir = first_probe(d_q) + probe_q;
    nr        = {1'b0, cx_q} + dir_dr(probe_dir);
    nc        = {1'b0, cy_q} + dir_dc(probe_dir);
    probe_pix = 1'b0;
    if (!nr[6] && !nc[6]) probe_pix = img[nr[5:0]][6'd63 - nc[5:0]];
    mr = 6'({1'b0, cx_q} + dir_dr(d_q));
    mc = 6'({1'b0, cy_q} + dir_dc(d_q));
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      row_q   <= '0;
      area_q  <= '0;
      found_q <= 1'b0;
      sx_q    <= '0;
      sy_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      d_q     <= '0;
      probe_q <= '0;
      perim_q <= '0;
      fail_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      area_q  <= area_d;
      found_q <= found_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      d_q     <= d_d;
      probe_q <= probe_d;
      perim_q <= perim_d;
      fail_q  <= fail_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic for the scan / search / emit sequence.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    area_d  = area_q;
    found_d = found_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    d_d     = d_q;
    probe_d = probe_q;
    perim_d = perim_q;
    fail_d  = fail_q;
    done_d  = done_q;
    err_d   = err_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          area_d  = '0;
          perim_d = '0;
          found_d = 1'b0;
          fail_d  = 1'b0;
          row_d   = '0;
          sx_d    = '0;
          sy_d    = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        area_d = area_q + (AreaW + 1)'(pop);
        if (!found_q && nz) begin
          found_d = 1'b1;
          sx_d    = row_q;
          sy_d    = lead;
        end
        row_d = row_q + 6'd1;
        if (row_q == 6'd63) begin
          if (!found_q && !nz) begin
            fail_d  = 1'b1;
            state_d = StDone;
          end else begin
            d_d     = 3'd7;
            probe_d = '0;
            cx_d    = found_q ? sx_q : row_q;
            cy_d    = found_q ? sy_q : lead;
            state_d = StSearch;
          end
        end
      end
      StSearch: begin
        if (probe_pix) begin
          if (perim_q == '1) begin
            fail_d  = 1'b1;
            state_d = StDone;
          end else begin
            d_d     = probe_dir;
            state_d = StEmit;
          end
        end else if (probe_q == 3'd7) begin
          // Isolated pixel: no boundary to walk.
          state_d = StDone;
        end else begin
          probe_d = probe_q + 3'd1;
        end
      end
      StEmit: begin
        if (code_ready) begin
          cx_d    = mr;
          cy_d    = mc;
          perim_d = perim_q + 9'd1;
          probe_d = '0;
          state_d = ((mr == sx_q) && (mc == sy_q)) ? StDone : StSearch;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        err_d   = fail_q | area_q[AreaW];
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign code_valid = (state_q == StEmit);
  assign code       = code_valid ? {5'b0, d_q} : 8'd0;
  assign startX     = sx_q;
  assign startY     = sy_q;
  assign area       = area_q[AreaW] ? '1 : area_q[AreaW-1:0];
  assign perimeter  = perim_q;
  assign done       = done_q;
  assign error      = err_q;

endmodule

// File: tb/tb_chain_code_encoder.sv
// Directed bench for chain_code_encoder: table of images with hand-traced
// expected codes, plus stall and mid-run reset sequences.
module tb_chain_code_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_valid = 1'b0;
  logic [5:0]  load_row = '0;
  logic [63:0] load_data = '0;
  logic        start = 1'b0;
  logic [7:0]  code;
  logic        code_valid;
  logic        code_ready = 1'b0;
  logic [5:0]  startX, startY;
  logic [11:0] area;
  logic [8:0]  perimeter;
  logic        done, error;

  always #5 clk = ~clk;

  chain_code_encoder dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_row   (load_row),
    .load_data  (load_data),
    .start      (start),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .startX     (startX),
    .startY     (startY),
    .area       (area),
    .perimeter  (perimeter),
    .done       (done),
    .error      (error)
  );

  // Image = union of two rectangles (a rectangle with r1 < r0 is empty).
  typedef struct {
    string       name;
    int          ra0, ra1, ca0, ca1;
    int          rb0, rb1, cb0, cb1;
    int          sx, sy, area, perim, err, ncodes, seq_chk, done_cyc;
    logic [23:0] codes;  // first code in [23:21]
  } vec_t;

  vec_t        vecs[5];
  logic [63:0] model [64];
  int          checks = 0;
  int          passes = 0;
  int          got[$];
  int          cyc;
  int          held_ok;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_vec(input vec_t v);
    for (int r = 0; r < 64; r++) begin
      model[r] = '0;
      for (int c = 0; c < 64; c++) begin
        if ((r >= v.ra0 && r <= v.ra1 && c >= v.ca0 && c <= v.ca1) ||
            (r >= v.rb0 && r <= v.rb1 && c >= v.cb0 && c <= v.cb1))
          model[r][63-c] = 1'b1;
      end
    end
    for (int r = 0; r < 64; r++) begin
      load_valid = 1'b1;
      load_row   = 6'(r);
      load_data  = model[r];
      step();
    end
    load_valid = 1'b0;
  endtask

  // Start an encode and collect codes; optionally stall one code and poke
  // load/start while the encoder is busy.
  task automatic run_encode(input int stall_at, input int stall_len, input int stall_code);
    int stalled;
    stalled = 0;
    got.delete();
    held_ok = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    code_ready = 1'b0;
    while (!done && cyc < 5000) begin
      load_valid = 1'b0;
      if (code_valid) begin
        if (got.size() == stall_at && stalled < stall_len) begin
          code_ready = 1'b0;
          if (code == 8'(stall_code)) held_ok++;
          if (stalled == 1) begin
            load_valid = 1'b1;
            load_row   = 6'd11;
            load_data  = '1;
          end
          if (stalled == 2) start = 1'b1;
          stalled++;
        end else begin
          code_ready = 1'b1;
          got.push_back(int'(code));
        end
      end else begin
        code_ready = 1'b0;
      end
      step();
      start = 1'b0;
      cyc++;
    end
    load_valid = 1'b0;
    code_ready = 1'b0;
    if (!done) check("timeout_done", 0, 1);
  endtask

  task automatic check_result(input vec_t v);
    logic [23:0] cw;
    int          exp_code;
    int          act_code;
    cw = v.codes;
    check({v.name, " startX"}, int'(startX), v.sx);
    check({v.name, " startY"}, int'(startY), v.sy);
    check({v.name, " area"}, int'(area), v.area);
    check({v.name, " perimeter"}, int'(perimeter), v.perim);
    check({v.name, " error"}, int'(error), v.err);
    check({v.name, " done"}, int'(done), 1);
    check({v.name, " code_count"}, got.size(), v.ncodes);
    if (v.seq_chk != 0) begin
      for (int i = 0; i < v.ncodes; i++) begin
        exp_code = int'(cw[23-3*i -: 3]);
        act_code = (i < got.size()) ? got[i] : -1;
        check($sformatf("%s code[%0d]", v.name, i), act_code, exp_code);
      end
    end
    if (v.done_cyc >= 0) check({v.name, " done_latency"}, cyc, v.done_cyc);
    repeat (3) step();
    check({v.name, " done_held"}, int'(done), 1);
    check({v.name, " perimeter_held"}, int'(perimeter), v.perim);
  endtask

  initial begin
    vec_t sv;

    repeat (3) @(posedge clk);
    #1;
    check("rst code_valid", int'(code_valid), 0);
    check("rst code", int'(code), 0);
    check("rst done", int'(done), 0);
    check("rst error", int'(error), 0);
    check("rst area", int'(area), 0);
    check("rst perimeter", int'(perimeter), 0);
    check("rst startX", int'(startX), 0);
    check("rst startY", int'(startY), 0);
    reset = 1'b1;
    step();

    vecs[0] = '{"square", 10, 12, 20, 22, 1, 0, 0, 0,
                10, 20, 9, 8, 0, 8, 1, 95,
                {3'd6, 3'd6, 3'd0, 3'd0, 3'd2, 3'd2, 3'd4, 3'd4}};
    vecs[1] = '{"diagonal", 5, 5, 5, 5, 6, 6, 6, 6,
                5, 5, 2, 2, 0, 2, 1, 77,
                {3'd7, 3'd3, 18'd0}};
    vecs[2] = '{"single", 0, 0, 0, 0, 1, 0, 0, 0,
                0, 0, 1, 0, 0, 0, 1, 73, 24'd0};
    vecs[3] = '{"empty", 1, 0, 0, 0, 1, 0, 0, 0,
                0, 0, 0, 0, 1, 0, 1, 65, 24'd0};
    vecs[4] = '{"full", 0, 63, 0, 63, 1, 0, 0, 0,
                0, 0, 4095, 252, 1, 252, 0, -1, 24'd0};

    for (int k = 0; k < 5; k++) begin
      load_vec(vecs[k]);
      run_encode(-1, 0, 0);
      check_result(vecs[k]);
    end

    // Stall the third code (value 0) for 5 cycles; busy-time load/start ignored.
    load_vec(vecs[0]);
    run_encode(2, 5, 0);
    sv = vecs[0];
    sv.name = "stall";
    sv.done_cyc = 100;
    check_result(sv);
    check("stall code_held", held_ok, 5);

    // Reset while in SEARCH, then rerun on the retained image.
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (64) step();
    check("pre_reset area", int'(area), 9);
    reset = 1'b0;
    #1;
    check("mid_reset code_valid", int'(code_valid), 0);
    check("mid_reset startX", int'(startX), 0);
    check("mid_reset startY", int'(startY), 0);
    check("mid_reset area", int'(area), 0);
    check("mid_reset perimeter", int'(perimeter), 0);
    check("mid_reset done", int'(done), 0);
    check("mid_reset error", int'(error), 0);
    #2;
    reset = 1'b1;
    step();
    run_encode(-1, 0, 0);
    sv = vecs[0];
    sv.name = "after_reset";
    check_result(sv);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
